// File: rtl/regfile_pkg.sv
// Shared types and limits for the register-file write arbiter.
// The global `BIT_COUNT sets the data width and defaults to 32.
`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif

package regfile_pkg;

  localparam int unsigned REQUESTER_COUNT_MAX    = 4;
  localparam int unsigned REGISTER_COUNT_DEFAULT = 32;
  localparam int unsigned BIT_COUNT              = `BIT_COUNT;

  typedef logic [$clog2(REGISTER_COUNT_DEFAULT)-1:0] rf_adr_t;

  typedef struct packed {
    logic                 valid;
    rf_adr_t              adr;
    logic [BIT_COUNT-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/flopRE.sv
// Enable flop with asynchronous active-low reset to zero.
module flopRE #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr,
// wrapping around. Returns one-hot grant and the encoded winner index.
module round_robin_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  ReqValid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic        w_found;
  int unsigned w_j;

  always_comb begin
    grant   = '0;
    idx     = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      w_j = (32'(ptr) + k) % N;
      if (!w_found && ReqValid[IW'(w_j)]) begin
        w_found          = 1'b1;
        grant[IW'(w_j)]  = 1'b1;
        idx              = IW'(w_j);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin share of the register-file write port with a registered write.
// Optional same-cycle forwarding of the in-flight write: RF_WRITE_ARB_BYPASS_EN.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter  int unsigned REGISTER_COUNT  = 32,
  parameter  int unsigned REQUESTER_COUNT = 2,
  localparam int unsigned AW = $clog2(REGISTER_COUNT),
  localparam int unsigned DW = BIT_COUNT,
  localparam int unsigned PW = $clog2(REQUESTER_COUNT)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [REQUESTER_COUNT-1:0]    ReqValid,
  input  logic [REQUESTER_COUNT*AW-1:0] ReqRdAdr,
  input  logic [REQUESTER_COUNT*DW-1:0] ReqData,
  output logic [REQUESTER_COUNT-1:0]    ReqReady,
  output logic                          WriteEn,
  output logic [AW-1:0]                 rd1Adr,
  output logic [DW-1:0]                 Rd1,
  output logic [REQUESTER_COUNT-1:0]    Grant
`ifdef RF_WRITE_ARB_BYPASS_EN
  ,
  input  logic [AW-1:0]                 rs1Adr,
  input  logic [AW-1:0]                 rs2Adr,
  output logic                          Rs1Bypass,
  output logic                          Rs2Bypass,
  output logic [DW-1:0]                 BypassData
`endif
);

  if (REQUESTER_COUNT < 2 || REQUESTER_COUNT > REQUESTER_COUNT_MAX) begin : g_bad_count
    $error("REQUESTER_COUNT out of range");
  end

  logic [PW-1:0]              r_ptr;
  logic [REQUESTER_COUNT-1:0] w_onehot;
  logic [PW-1:0]              w_idx;
  logic                       w_accept;
  logic [AW-1:0]              w_sel_adr;
  logic [DW-1:0]              w_sel_data;
  logic                       w_we_d;
  logic [PW-1:0]              w_ptr_next;

  round_robin_arbiter #(.N(REQUESTER_COUNT)) u_arb (
    .ReqValid (ReqValid),
    .ptr      (r_ptr),
    .grant    (w_onehot),
    .idx      (w_idx)
  );

  // The winner is always ready, so any one-hot bit is an acceptance.
  assign ReqReady   = w_onehot;
  assign w_accept   = |w_onehot;
  assign w_sel_adr  = ReqRdAdr[w_idx*AW +: AW];
  assign w_sel_data = ReqData[w_idx*DW +: DW];
  assign w_we_d     = w_accept && (w_sel_adr != '0);
  assign w_ptr_next = (w_idx == PW'(REQUESTER_COUNT - 1)) ? '0 : w_idx + PW'(1);

  flopRE #(.WIDTH(1)) u_we (
    .clk (clk), .reset (reset), .en (1'b1), .d (w_we_d), .q (WriteEn)
  );

  flopRE #(.WIDTH(REQUESTER_COUNT)) u_grant (
    .clk (clk), .reset (reset), .en (1'b1), .d (w_onehot), .q (Grant)
  );

  flopRE #(.WIDTH(AW)) u_adr (
    .clk (clk), .reset (reset), .en (w_accept), .d (w_sel_adr), .q (rd1Adr)
  );

  flopRE #(.WIDTH(DW)) u_data (
    .clk (clk), .reset (reset), .en (w_accept), .d (w_sel_data), .q (Rd1)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= w_ptr_next;
    end
  end

`ifdef RF_WRITE_ARB_BYPASS_EN
  assign Rs1Bypass  = WriteEn && (rs1Adr == rd1Adr);
  assign Rs2Bypass  = WriteEn && (rs2Adr == rd1Adr);
  assign BypassData = Rd1;
`endif

endmodule
